// File: rtl/div_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multi-cycle divider.
// The pipeline holds valid and the operands until data_ok; stall freezes upstream stages.
interface div_sequencer_if #(
    parameter int unsigned WIDTH = 64
);
    logic             valid;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             is_rem;
    logic             is_word;
    logic             stall;
    logic             data_ok;
    logic [WIDTH-1:0] result;

    modport master (
        output valid, flush, a, b, is_signed, is_rem, is_word,
        input  stall, data_ok, result
    );

    modport slave (
        input  valid, flush, a, b, is_signed, is_rem, is_word,
        output stall, data_ok, result
    );
endinterface

// File: rtl/div_sequencer.sv
// RV64M divide/remainder sequencer: radix-2 restoring divider on operand magnitudes,
// with sign fix-up and W-op sign extension applied in a single cycle after the iteration.
module div_sequencer #(
    parameter int unsigned WIDTH = 64
) (
    input logic            clk,
    input logic            reset,
    div_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] result_q;
    logic             q_neg;
    logic             r_neg;
    logic             rem_sel;
    logic             word_sel;

    logic             accept;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic             last_iter;
    logic             take;
    logic             done_ok;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] special_val;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_val;
    logic [WIDTH:0]   shifted;

    function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] v, input logic w);
        return w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        accept    = bus.valid && !bus.flush;
        abs_a     = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b     = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        div_zero  = (bus.b == '0);
        overflow  = bus.is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
        special   = div_zero || overflow;
        if (div_zero)
            special_val = bus.is_rem ? bus.a : '1;
        else
            special_val = bus.is_rem ? '0 : bus.a;

        // Shifted remainder needs one extra bit; after a successful subtract it fits WIDTH again.
        shifted   = {rem_q, quo_q[WIDTH-1]};
        take      = (shifted >= {1'b0, mag_b});
        trial     = shifted[WIDTH-1:0] - mag_b;
        last_iter = (count == CW'(WIDTH - 1));

        q_fix     = q_neg ? -quo_q : quo_q;
        r_fix     = r_neg ? -rem_q : rem_q;
        fix_val   = sext_word(rem_sel ? r_fix : q_fix, word_sel);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush)
            state_nxt = IDLE;
    end

    always_comb begin
        done_ok     = (state == DONE) && !bus.flush;
        bus.data_ok = done_ok;
        bus.stall   = bus.valid && !done_ok;
        bus.result  = result_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            mag_b    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            rem_sel  <= 1'b0;
            word_sel <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= '0;
                        mag_b    <= abs_b;
                        rem_q    <= '0;
                        quo_q    <= abs_a;
                        q_neg    <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg    <= bus.is_signed && bus.a[WIDTH-1];
                        rem_sel  <= bus.is_rem;
                        word_sel <= bus.is_word;
                        if (special)
                            result_q <= sext_word(special_val, bus.is_word);
                    end
                end
                CALC: begin
                    rem_q <= take ? trial : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], take};
                    if (!last_iter)
                        count <= count + CW'(1);
                end
                FIXUP: begin
                    result_q <= fix_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected result and latency are queued at drive time
// and compared when data_ok arrives; also covers flush and asynchronous reset behaviour.
module tb_div_sequencer;
    localparam int unsigned W = 64;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    div_sequencer_if #(.WIDTH(W)) bus();
    div_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic s, input logic r, input logic w);
        logic [W-1:0] q, m, res;
        if (bv == '0) begin
            q = '1; m = av;
        end else if (s && av == MIN && bv == '1) begin
            q = av; m = '0;
        end else if (s) begin
            q = W'($signed(av) / $signed(bv));
            m = W'($signed(av) % $signed(bv));
        end else begin
            q = av / bv; m = av % bv;
        end
        res = r ? m : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic s, input logic r, input logic w);
        bus.valid = 1'b1; bus.flush = 1'b0;
        bus.a = av; bus.b = bv;
        bus.is_signed = s; bus.is_rem = r; bus.is_word = w;
    endtask

    task automatic push(input logic [W-1:0] e, input int l);
        exp_q.push_back(e);
        lat_q.push_back(l);
    endtask

    // Called at a negedge with the request already driven; acceptance is the next posedge.
    task automatic wait_done(input string tag);
        int cyc = 0;
        int stall_bad = 0;
        bit got = 0;
        logic [W-1:0] e;
        int l;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.data_ok === 1'b1) begin
                got = 1;
            end else begin
                if (bus.stall !== 1'b1) stall_bad++;
                if (cyc == 1) begin
                    bus.a = {$urandom, $urandom};
                    bus.b = {$urandom, $urandom};
                    bus.is_rem = ~bus.is_rem;
                    bus.is_signed = ~bus.is_signed;
                end
            end
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if (!got) begin
            check({tag, " timeout"}, W'(0), W'(1));
        end else begin
            check({tag, " result"}, bus.result, e);
            check({tag, " latency"}, W'(cyc), W'(l));
            check({tag, " stall_at_ok"}, W'(bus.stall), W'(0));
        end
        check({tag, " stall_busy"}, W'(stall_bad), W'(0));
        bus.valid = 1'b0;
        @(negedge clk);
        check({tag, " pulse"}, W'(bus.data_ok), W'(0));
    endtask

    task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input logic r, input logic w,
                       input logic [W-1:0] e, input int l);
        push(e, l);
        drive(av, bv, s, r, w);
        wait_done(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs, rr, rw;
        int rl;

        reset = 1'b1;
        bus.valid = 1'b0; bus.flush = 1'b0;
        bus.a = '0; bus.b = '0;
        bus.is_signed = 1'b0; bus.is_rem = 1'b0; bus.is_word = 1'b0;
        #12;
        check("rst data_ok", W'(bus.data_ok), W'(0));
        check("rst result", bus.result, W'(0));
        check("rst stall_lo", W'(bus.stall), W'(0));
        bus.valid = 1'b1;
        #1;
        check("rst stall_hi", W'(bus.stall), W'(1));
        bus.valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run("divu", 64'd100, 64'd7, 0, 0, 0, 64'd14, 66);
        run("remu", 64'd100, 64'd7, 0, 1, 0, 64'd2, 66);
        run("div_neg", -64'd7, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run("rem_neg", -64'd7, 64'd2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("rem_negb", 64'd7, -64'd2, 1, 1, 0, 64'd1, 66);
        run("div_by0", 64'd5, 64'd0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run("remu_by0", 64'd5, 64'd0, 0, 1, 0, 64'd5, 1);
        run("div_ovf", MIN, '1, 1, 0, 0, MIN, 1);
        run("rem_ovf", MIN, '1, 1, 1, 0, 64'd0, 1);
        run("divuw", 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("divw_ovf", 64'hFFFF_FFFF_8000_0000, '1, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, 66);
        run("divw_by0", 64'd9, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rw = (i >= 4);
            if (rw) begin
                ra = rs ? {{32{1'b1}}, 32'($urandom)} : {32'd0, 32'($urandom)};
                ra = rs ? {{32{ra[31]}}, ra[31:0]} : ra;
                rb = {32'd0, 32'($urandom_range(1, 70000))};
                if (rs && i == 5) rb = -rb;
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom} >> $urandom_range(0, 60);
            end
            rl = (rb == '0 || (rs && ra == MIN && rb == '1)) ? 1 : 66;
            run("rand", ra, rb, rs, rr, rw, model(ra, rb, rs, rr, rw), rl);
        end

        // flush together with valid in IDLE must not accept
        drive(64'd5, 64'd0, 0, 0, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        check("idle_flush state", W'(dut.state), W'(0));
        check("idle_flush ok", W'(bus.data_ok), W'(0));
        bus.flush = 1'b0; bus.valid = 1'b0;
        @(negedge clk);

        // flush in DONE suppresses data_ok
        drive(64'd5, 64'd0, 0, 0, 0);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.valid = 1'b0;
        #1;
        check("done_flush ok", W'(bus.data_ok), W'(0));
        @(negedge clk);
        check("done_flush state", W'(dut.state), W'(0));
        check("done_flush ok2", W'(bus.data_ok), W'(0));
        bus.flush = 1'b0;

        // flush in CALC cycle 30, then a fresh request the cycle after
        drive(64'd1000, 64'd3, 0, 0, 0);
        repeat (30) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        check("calc_flush state", W'(dut.state), W'(0));
        check("calc_flush ok", W'(bus.data_ok), W'(0));
        push(64'd3, 66);
        drive(64'd9, 64'd3, 0, 0, 0);
        wait_done("after_flush");

        // asynchronous reset between edges mid-CALC, release with valid held
        drive(64'd100, 64'd7, 0, 0, 0);
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst ok", W'(bus.data_ok), W'(0));
        check("arst state", W'(dut.state), W'(0));
        check("arst result", bus.result, W'(0));
        @(negedge clk);
        reset = 1'b0;
        push(64'd14, 66);
        wait_done("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and datapath for the RV64M divide family: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits in execute beside the single-cycle ALU.
- Receives the operands that decode has already prepared: for W ops, sign-extended for signed ops and zero-extended for unsigned ops.
- Runs a radix-2 restoring iteration and holds the pipeline through its stall output until the result is ready.

Parameters:
- WIDTH, 64, operand/result width and number of iteration cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  divide request present in execute; held high by the pipeline until data_ok.
- flush  in  1  kill the in-flight request (redirect/exception); synchronous.
- a  in  WIDTH  dividend (rd1 from decode).
- b  in  WIDTH  divisor (rd2 from decode).
- is_signed  in  1  1 = DIV/REM/DIVW/REMW.
- is_rem  in  1  1 = return remainder, 0 = return quotient.
- is_word  in  1  1 = W op; result is sign-extended from bit 31.
- stall  out  1  valid & ~data_ok; the pipeline freezes the upstream stages on this.
- data_ok  out  1  one-cycle pulse; result valid this cycle.
- result  out  WIDTH  quotient or remainder; meaningful only when data_ok=1.

Behaviour:
- States: IDLE, CALC, FIXUP, DONE.
- Reset (asynchronous, any state): state=IDLE, counter=0, all internal registers=0, data_ok=0, result=0. stall follows valid combinationally.
- IDLE: when valid=1 and flush=0 at a rising edge, the request is accepted.
  - Latch |a| and |b| as magnitudes; unsigned ops use the raw value.
  - Latch the quotient sign (a[WIDTH-1]^b[WIDTH-1]) and the remainder sign (a[WIDTH-1]), both only when is_signed.
  - Latch is_rem, is_word, and a copy of a.
- Special cases on acceptance go straight to DONE with the final result preloaded:
  - b==0: quotient = all ones; remainder = a.
  - Signed with a==100...0 and b==all ones: quotient = a; remainder = 0.
  - is_word is applied afterwards. Example: DIVW by zero gives 0xFFFF_FFFF_FFFF_FFFF.
- Otherwise IDLE goes to CALC with counter=0, partial remainder R=0, and Q=|a|.
- CALC, one iteration per cycle for WIDTH cycles:
  - {R,Q} shifted left by 1.
  - If the shifted R >= |b|: R = R - |b| and the Q LSB = 1.
  - Move to FIXUP when counter==WIDTH-1; the counter does not wrap.
- FIXUP, one cycle:
  - Negate Q if the quotient sign is set; negate R if the remainder sign is set.
  - Select R or Q by is_rem.
  - If is_word, sign-extend from bit 31.
  - Register the result and go to DONE.
- DONE, one cycle: data_ok=1 and result is driven; the next state is IDLE. valid is ignored in DONE; a new request is accepted no earlier than the following IDLE cycle.
- Latency:
  - Normal request accepted at edge E0: data_ok is high in cycle E0+WIDTH+2, which is cycle 66 for WIDTH=64.
  - Special case: data_ok is high in the cycle immediately after E0.
- Operands are sampled only at acceptance; later changes on a/b/is_* while busy are ignored.
- flush=1 in any state: next state IDLE and no data_ok. flush in the same cycle as DONE suppresses data_ok; the result is discarded.
- flush and valid both high in IDLE: no acceptance.
- Result width: the 64-bit computation on pre-extended W operands is exact.
  - DIVW -2^31/-1 gives 2^31, which sign-extends to 0xFFFF_FFFF_8000_0000 as required.
  - DIVUW results are also sign-extended from bit 31.

Test Plan:
- DIVU a=100 b=7 is_rem=0, then REMU same operands -> result=14 and result=2; each with data_ok exactly 66 cycles after acceptance and stall=1 for the 65 cycles before.
- DIV a=-7 b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1); REM a=7 b=-2 -> 1.
- DIV a=5 b=0 -> all ones; REMU a=5 b=0 -> 5; signed DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 and REM -> 0. All of these give data_ok 1 cycle after acceptance.
- DIVUW a=0x0000_0000_FFFF_FFFF b=1 -> 0xFFFF_FFFF_FFFF_FFFF; DIVW a=0xFFFF_FFFF_8000_0000 b=-1 -> 0xFFFF_FFFF_8000_0000.
- Flush in CALC cycle 30 -> no data_ok, state IDLE next cycle. A new DIVU 9/3 accepted the cycle after -> 3 with full 66-cycle latency.
- Assert reset asynchronously (between edges) mid-CALC -> data_ok=0 and state IDLE immediately. Deassert reset with valid held high -> request accepted at the next edge and completes normally.
